// File: rtl/rv_pkg.sv
// Shared RV32I pipeline definitions.
// funct3 load/store size codes and the MEM stage FSM state type.
package rv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/memory_stage_if.sv
// Data memory req/gnt/rvalid bus.
// master: req, we, addr, wdata, wstrb out; gnt, rvalid, rdata in.
interface memory_stage_if #(
    parameter int DMEM_AW = 32
);
    logic               req;
    logic               we;
    logic [DMEM_AW-1:0] addr;
    logic [31:0]        wdata;
    logic [3:0]         wstrb;
    logic               gnt;
    logic               rvalid;
    logic [31:0]        rdata;

    modport master (
        output req, we, addr, wdata, wstrb,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata, wstrb,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/mem_lane_align.sv
// Combinational lane logic: store strobes/data, load extraction, fault check.
// In: addr_lo, store_data, funct3, mem_read/write, ld_off, ld_f3, rdata.
// Out: wdata, wstrb, fault, ld_data.
module mem_lane_align
    import rv_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [2:0]  funct3,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        fault,
    input  logic [1:0]  ld_off,
    input  logic [2:0]  ld_f3,
    input  logic [31:0] rdata,
    output logic [31:0] ld_data
);
    logic [31:0] shifted;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        fault = 1'b0;
        if (mem_read && mem_write) begin
            fault = 1'b1;
        end else if (mem_read || mem_write) begin
            case (funct3)
                F3_B:    fault = 1'b0;
                F3_H:    fault = addr_lo[0];
                F3_W:    fault = |addr_lo;
                // unsigned sizes exist only for loads
                F3_BU:   fault = mem_write;
                F3_HU:   fault = mem_write | addr_lo[0];
                default: fault = 1'b1;
            endcase
        end
    end

    always_comb begin
        wdata = store_data;
        wstrb = 4'b0000;
        if (mem_write) begin
            case (funct3)
                F3_B: begin
                    wdata = {4{store_data[7:0]}};
                    wstrb = 4'b0001 << addr_lo;
                end
                F3_H: begin
                    wdata = {2{store_data[15:0]}};
                    wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
                end
                F3_W:    wstrb = 4'b1111;
                default: wstrb = 4'b0000;
            endcase
        end
    end

    always_comb begin
        shifted = rdata >> {ld_off, 3'b000};
        lane_b  = shifted[7:0];
        lane_h  = ld_off[1] ? rdata[31:16] : rdata[15:0];
        case (ld_f3)
            F3_B:    ld_data = {{24{lane_b[7]}}, lane_b};
            F3_H:    ld_data = {{16{lane_h[15]}}, lane_h};
            F3_BU:   ld_data = {24'd0, lane_b};
            F3_HU:   ld_data = {16'd0, lane_h};
            default: ld_data = rdata;
        endcase
    end
endmodule

// File: rtl/memory_stage.sv
// RV32I MEM stage: issues loads/stores over the dmem bus, registers MEM/WB.
// Ports: clk, rst, EX/MEM inputs, mem_stall, dmem bus (master), wb_*, mem_fault.
module memory_stage
    import rv_pkg::*;
#(
    parameter int DMEM_AW = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_valid,
    input  logic [31:0]           alu_result,
    input  logic [31:0]           store_data,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [2:0]            funct3,
    input  logic [4:0]            rd,
    input  logic                  reg_write,
    output logic                  mem_stall,
    memory_stage_if.master        dmem,
    output logic                  wb_valid,
    output logic [31:0]           wb_data,
    output logic [4:0]            wb_rd,
    output logic                  wb_reg_write,
    output logic                  mem_fault,
    output logic [31:0]           fault_addr
);
    state_t      state;
    logic [31:0] cap_addr;
    logic [2:0]  cap_f3;
    logic [4:0]  cap_rd;
    logic        cap_rw;
    logic        cap_load;

    logic [31:0] st_wdata;
    logic [3:0]  st_wstrb;
    logic        chk_fault;
    logic [31:0] ld_data;
    logic        mem_op;

    assign mem_op    = mem_read | mem_write;
    assign mem_stall = (state != IDLE);

    mem_lane_align u_align (
        .addr_lo    (alu_result[1:0]),
        .store_data (store_data),
        .funct3     (funct3),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .wdata      (st_wdata),
        .wstrb      (st_wstrb),
        .fault      (chk_fault),
        .ld_off     (cap_addr[1:0]),
        .ld_f3      (cap_f3),
        .rdata      (dmem.rdata),
        .ld_data    (ld_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            dmem.req     <= 1'b0;
            dmem.we      <= 1'b0;
            dmem.addr    <= '0;
            dmem.wdata   <= '0;
            dmem.wstrb   <= '0;
            wb_valid     <= 1'b0;
            wb_data      <= '0;
            wb_rd        <= '0;
            wb_reg_write <= 1'b0;
            mem_fault    <= 1'b0;
            fault_addr   <= '0;
            cap_addr     <= '0;
            cap_f3       <= '0;
            cap_rd       <= '0;
            cap_rw       <= 1'b0;
            cap_load     <= 1'b0;
        end else begin
            // wb_valid and mem_fault are single-cycle pulses
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            mem_fault    <= 1'b0;
            case (state)
                IDLE: begin
                    if (ex_valid) begin
                        if (mem_op && chk_fault) begin
                            mem_fault  <= 1'b1;
                            fault_addr <= alu_result;
                            wb_valid   <= 1'b1;
                            wb_data    <= alu_result;
                            wb_rd      <= rd;
                        end else if (mem_op) begin
                            dmem.req   <= 1'b1;
                            dmem.we    <= mem_write;
                            dmem.addr  <= {alu_result[DMEM_AW-1:2], 2'b00};
                            dmem.wdata <= st_wdata;
                            dmem.wstrb <= st_wstrb;
                            cap_addr   <= alu_result;
                            cap_f3     <= funct3;
                            cap_rd     <= rd;
                            cap_rw     <= reg_write;
                            cap_load   <= mem_read;
                            state      <= REQ;
                        end else begin
                            wb_valid     <= 1'b1;
                            wb_data      <= alu_result;
                            wb_rd        <= rd;
                            wb_reg_write <= reg_write;
                        end
                    end
                end
                REQ: begin
                    if (dmem.gnt) begin
                        dmem.req <= 1'b0;
                        dmem.we  <= 1'b0;
                        if (!cap_load) begin
                            wb_valid <= 1'b1;
                            wb_data  <= cap_addr;
                            wb_rd    <= cap_rd;
                            state    <= IDLE;
                        end else if (dmem.rvalid) begin
                            // gnt and rvalid together skip RESP
                            wb_valid     <= 1'b1;
                            wb_data      <= ld_data;
                            wb_rd        <= cap_rd;
                            wb_reg_write <= cap_rw;
                            state        <= IDLE;
                        end else begin
                            state <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (dmem.rvalid) begin
                        wb_valid     <= 1'b1;
                        wb_data      <= ld_data;
                        wb_rd        <= cap_rd;
                        wb_reg_write <= cap_rw;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- MEM stage of the 5-stage RV32I pipeline, directly downstream of the execute stage.
- Consumes the EX/MEM-registered ALU result, rs2 data and memory control, and performs load/store to data memory over a req/gnt/rvalid handshake.
- Handles byte/half/word lane steering, store strobes, load sign/zero extension and alignment checks.
- Registers the MEM/WB outputs and stalls upstream while a memory access is outstanding.

Parameters:
- DMEM_AW, 32, width of dmem_addr; the low 2 bits are always driven 0 (word-aligned address).

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- ex_valid  in  1  EX/MEM register holds a valid instruction
- alu_result  in  32  effective address for loads/stores; pass-through data otherwise
- store_data  in  32  rs2 value for stores
- mem_read  in  1  instruction is a load
- mem_write  in  1  instruction is a store
- funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- rd  in  5  destination register
- reg_write  in  1  writeback enable
- mem_stall  out  1  upstream must hold the EX/MEM register
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = store
- dmem_addr  out  DMEM_AW  word-aligned address
- dmem_wdata  out  32  lane-replicated store data
- dmem_wstrb  out  4  byte strobes
- dmem_gnt  in  1  request accepted this cycle
- dmem_rvalid  in  1  load data valid
- dmem_rdata  in  32  load word
- wb_valid  out  1  MEM/WB holds a valid instruction
- wb_data  out  32  load result or alu_result
- wb_rd  out  5  destination register
- wb_reg_write  out  1  writeback enable (forced 0 on fault)
- mem_fault  out  1  one-cycle pulse: misaligned access or illegal funct3
- fault_addr  out  32  faulting address, held until the next fault

Behaviour:
- Reset:
  - State returns to IDLE.
  - wb_valid, wb_reg_write, dmem_req, dmem_we, mem_fault, mem_stall are 0.
  - wb_data, wb_rd, dmem_addr, dmem_wdata, dmem_wstrb, fault_addr are 0.
  - Reset mid-access drops dmem_req immediately. A dmem_rvalid arriving in IDLE is ignored.
- FSM states:
  - IDLE: accepts an instruction when ex_valid.
  - REQ: dmem_req held high until dmem_gnt.
  - RESP: loads only; waits for dmem_rvalid.
- mem_stall = (state != IDLE), driven combinationally.
- Instructions are accepted only in IDLE.
- IDLE, ex_valid, no memory op: wb_* loaded with alu_result/rd/reg_write next edge, wb_valid=1 (latency 1).
- IDLE, ex_valid, memory op, legal and aligned:
  - Capture address/data/size/rd into internal registers.
  - Drive dmem_* next cycle and go to REQ. wb_valid=0 while in REQ/RESP.
- REQ with dmem_gnt:
  - Store: go to IDLE; wb_valid=1 with wb_reg_write=0 on the same edge.
  - Load: go to RESP.
  - dmem_req, dmem_addr, dmem_we, dmem_wdata and dmem_wstrb are stable until gnt.
- RESP with dmem_rvalid: wb_data = extracted/extended lane, wb_valid=1, go to IDLE. Load-to-wb latency is 1 cycle after rvalid.
- Fast path: gnt and rvalid in the same cycle in REQ are legal. This completes as if RESP had been entered and rvalid seen.
- wb_valid is a one-cycle pulse per retired instruction. It is 0 when IDLE and ex_valid=0.
- Store steering:
  - SB: wdata = {4{byte}}, wstrb = 0001 shifted left by addr[1:0].
  - SH: wdata = {2{half}}, wstrb = 0011 or 1100 by addr[1].
  - SW: wstrb = 1111.
- Load extraction: select lane by captured addr[1:0]. B/H sign-extend; BU/HU zero-extend.
- Faults are checked in IDLE:
  - H/HU/SH with addr[0]=1 → fault.
  - W with addr[1:0]≠0 → fault.
  - funct3 ∉ {000,001,010,100,101} with a memory op → fault; this includes 100/101 on a store.
  - Action: no memory request is issued. Next edge: mem_fault=1, fault_addr=alu_result, wb_valid=1, wb_reg_write=0. No stall.
- mem_read and mem_write both high: treated as a fault.

Decomposition:
- Shared package (`rv_pkg`): funct3 size constants (F3_B, F3_H, F3_W, F3_BU, F3_HU) and the FSM state enum (IDLE/REQ/RESP).
- One combinational sub-module `mem_lane_align` holds store wdata/wstrb generation, load extraction/extension and the fault check. The FSM and registers stay in `memory_stage`.

Test Plan:
- ALU-only: ex_valid, alu_result=0x1234, rd=5, reg_write=1 → next cycle wb_valid=1, wb_data=0x1234, wb_rd=5, mem_stall never high.
- SB, addr=0x103, store_data=0xAB → dmem_addr=0x100, wstrb=1000, wdata=0xABABABAB, dmem_we=1. With gnt after 3 wait cycles, mem_stall is high 4 cycles and wb_reg_write=0.
- LB, addr=0x102, rdata=0x0080_0000, gnt then rvalid 2 cycles later → wb_data=0xFFFFFF80. LBU at the same address → 0x00000080.
- LW, addr=0x200, gnt and rvalid in the same cycle, rdata=0xDEADBEEF → wb_data=0xDEADBEEF one cycle later, no RESP dwell.
- LH, addr=0x301 → no dmem_req, mem_fault pulse, fault_addr=0x301, wb_reg_write=0. SW at 0x302 → same behaviour.
- rst asserted while in RESP → next cycle IDLE, outputs at reset values. A late rvalid is ignored, and the following ALU-only instruction retires normally.
